bin_weight_mac_seq: RTL and testbench



---
 rtl/bin_weight_mac_seq.sv | 161 ++++++++++++++++
 tb/tb_bin_weight_mac_seq.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_weight_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_weight_mac_seq
// Summary  : Tiled matrix-vector MAC with +/-1 weights and saturating output.
// Revision : 1.0 - initial release
// ============================================================================
module bin_weight_mac_seq #(
  parameter int IN_DIM    = 8,
  parameter int OUT_DIM   = 8,
  parameter int BIT_CNT   = 8,
  parameter int LANES     = 2,
  parameter int MAX_TILES = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [IN_DIM-1:0][BIT_CNT-1:0]    value_in,
  input  logic [OUT_DIM-1:0][IN_DIM-1:0]    weight,
  input  logic                              last_tile,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_DIM-1:0][BIT_CNT-1:0]   value_out,
  output logic [OUT_DIM-1:0]                sat_flag
);

  localparam int ACC_W = BIT_CNT + $clog2(IN_DIM * MAX_TILES) + 1;
  localparam int PTR_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int CNT_W = $clog2(MAX_TILES + 1);

  localparam logic [PTR_W-1:0]        c_last_ptr  = PTR_W'(OUT_DIM - LANES);
  localparam logic [PTR_W-1:0]        c_lane_step = PTR_W'(LANES);
  localparam logic [CNT_W-1:0]        c_max_tiles = CNT_W'(MAX_TILES);
  localparam logic signed [ACC_W-1:0] c_sat_max   = ACC_W'((64'sd1 <<< (BIT_CNT - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] c_sat_min   = ~c_sat_max;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  state_t                           r_state;
  logic [IN_DIM-1:0][BIT_CNT-1:0]   r_value;
  logic [OUT_DIM-1:0][IN_DIM-1:0]   r_weight;
  logic                             r_last;
  logic [PTR_W-1:0]                 r_row_ptr;
  logic [CNT_W-1:0]                 r_tile_cnt;
  logic signed [ACC_W-1:0]          r_acc [OUT_DIM];
  logic                             r_out_valid;
  logic [OUT_DIM-1:0][BIT_CNT-1:0]  r_value_out;
  logic [OUT_DIM-1:0]               r_sat;

  logic [PTR_W-1:0]                 w_row [LANES];
  logic signed [ACC_W-1:0]          w_sum [LANES];
  logic [CNT_W-1:0]                 w_cnt_inc;
  logic                             w_to_output;

  // Sign-extend before negating so that -(-2^(BIT_CNT-1)) is representable.
  function automatic logic signed [ACC_W-1:0] sx(input logic [BIT_CNT-1:0] v);
    return {{(ACC_W - BIT_CNT){v[BIT_CNT-1]}}, v};
  endfunction

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_row[l] = r_row_ptr + PTR_W'(l);
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_sum[l] = '0;
      for (int j = 0; j < IN_DIM; j++) begin
        if (r_weight[w_row[l]][j]) begin
          w_sum[l] = w_sum[l] + sx(r_value[j]);
        end else begin
          w_sum[l] = w_sum[l] - sx(r_value[j]);
        end
      end
    end
  end

  assign w_cnt_inc   = r_tile_cnt + CNT_W'(1);
  assign w_to_output = r_last || (w_cnt_inc == c_max_tiles);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_value     <= '0;
      r_weight    <= '0;
      r_last      <= 1'b0;
      r_row_ptr   <= '0;
      r_tile_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_value_out <= '0;
      r_sat       <= '0;
      for (int i = 0; i < OUT_DIM; i++) begin
        r_acc[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_value   <= value_in;
            r_weight  <= weight;
            r_last    <= last_tile;
            r_row_ptr <= '0;
            r_state   <= S_COMPUTE;
          end
        end

        S_COMPUTE: begin
          for (int l = 0; l < LANES; l++) begin
            r_acc[w_row[l]] <= r_acc[w_row[l]] + w_sum[l];
          end
          r_row_ptr <= r_row_ptr + c_lane_step;
          if (r_row_ptr == c_last_ptr) begin
            r_row_ptr  <= '0;
            r_tile_cnt <= w_cnt_inc;
            r_state    <= w_to_output ? S_OUTPUT : S_IDLE;
          end
        end

        S_OUTPUT: begin
          // First OUTPUT cycle registers the clamped result; later cycles hold it.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            for (int i = 0; i < OUT_DIM; i++) begin
              if (r_acc[i] > c_sat_max) begin
                r_value_out[i] <= c_sat_max[BIT_CNT-1:0];
                r_sat[i]       <= 1'b1;
              end else if (r_acc[i] < c_sat_min) begin
                r_value_out[i] <= c_sat_min[BIT_CNT-1:0];
                r_sat[i]       <= 1'b1;
              end else begin
                r_value_out[i] <= r_acc[i][BIT_CNT-1:0];
                r_sat[i]       <= 1'b0;
              end
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_tile_cnt  <= '0;
            r_state     <= S_IDLE;
            for (int i = 0; i < OUT_DIM; i++) begin
              r_acc[i] <= '0;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !reset;
  assign out_valid = r_out_valid;
  assign value_out = r_value_out;
  assign sat_flag  = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_bin_weight_mac_seq.sv
`default_nettype none
// Testbench for bin_weight_mac_seq: directed scenarios plus random tiles
// checked every cycle against a transaction-level arithmetic model.
module tb_bin_weight_mac_seq;

  localparam int TIN  = 4;
  localparam int TOUT = 4;
  localparam int TBC  = 8;
  localparam int TL   = 2;
  localparam int TMAX = 4;
  localparam int P    = TOUT / TL;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic [TIN-1:0][TBC-1:0]   value_in;
  logic [TOUT-1:0][TIN-1:0]  weight;
  logic                      last_tile;
  logic                      out_valid;
  logic                      out_ready;
  logic [TOUT-1:0][TBC-1:0]  value_out;
  logic [TOUT-1:0]           sat_flag;

  bin_weight_mac_seq #(
    .IN_DIM(TIN), .OUT_DIM(TOUT), .BIT_CNT(TBC), .LANES(TL), .MAX_TILES(TMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .value_in(value_in), .weight(weight), .last_tile(last_tile),
    .out_valid(out_valid), .out_ready(out_ready),
    .value_out(value_out), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_en  = 1'b0;

  // Model state: plain integer sums, expected visible outputs.
  int  m_acc [TOUT];
  int  m_cnt;
  bit  exp_in_ready;
  bit  exp_valid;
  int  exp_vout [TOUT];
  bit  exp_sat [TOUT];

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(in_ready), int'(exp_in_ready));
      chk("out_valid", int'(out_valid), int'(exp_valid));
      for (int i = 0; i < TOUT; i++) begin
        chk($sformatf("value_out[%0d]", i), int'($signed(value_out[i])), exp_vout[i]);
        chk($sformatf("sat_flag[%0d]", i), int'(sat_flag[i]), int'(exp_sat[i]));
      end
    end
  end

  function automatic logic [TIN-1:0][TBC-1:0] mk_v(input int a, input int b, input int c, input int d);
    logic [TIN-1:0][TBC-1:0] r;
    r[0] = a[7:0]; r[1] = b[7:0]; r[2] = c[7:0]; r[3] = d[7:0];
    return r;
  endfunction

  function automatic logic [TOUT-1:0][TIN-1:0] mk_w(input logic [3:0] r0, input logic [3:0] r1,
                                                    input logic [3:0] r2, input logic [3:0] r3);
    logic [TOUT-1:0][TIN-1:0] r;
    r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
    return r;
  endfunction

  function automatic int row_sum(input logic [TIN-1:0][TBC-1:0] v, input logic [TIN-1:0] w);
    int s = 0;
    for (int j = 0; j < TIN; j++) begin
      if (w[j]) s += int'($signed(v[j]));
      else      s -= int'($signed(v[j]));
    end
    return s;
  endfunction

  function automatic logic [7:0] rnd_byte();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0:       return 8'h7f;
      1:       return 8'h80;
      default: return r[7:0];
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage();
    logic [31:0] r;
    r = $urandom;
    in_valid  = r[0];
    last_tile = r[1];
    out_ready = r[2];
    weight    = r[31:16];
    value_in  = $urandom;
  endtask

  task automatic model_clear();
    for (int i = 0; i < TOUT; i++) m_acc[i] = 0;
    m_cnt = 0;
  endtask

  // Presents one tile while the unit is idle; returns whether it closed a result.
  task automatic send_tile(input logic [TIN-1:0][TBC-1:0] v, input logic [TOUT-1:0][TIN-1:0] w,
                           input bit last, output bit fin);
    value_in  = v;
    weight    = w;
    last_tile = last;
    in_valid  = 1'b1;
    step();
    for (int i = 0; i < TOUT; i++) m_acc[i] += row_sum(v, w[i]);
    m_cnt++;
    fin = last || (m_cnt == TMAX);
    exp_in_ready = 1'b0;
    for (int k = 0; k < P; k++) begin
      garbage();
      step();
    end
    if (!fin) begin
      in_valid     = 1'b0;
      out_ready    = 1'b0;
      exp_in_ready = 1'b1;
    end else begin
      garbage();
      step();
      out_ready = 1'b0;
      exp_valid = 1'b1;
      for (int i = 0; i < TOUT; i++) begin
        exp_vout[i] = (m_acc[i] > 127) ? 127 : (m_acc[i] < -128) ? -128 : m_acc[i];
        exp_sat[i]  = (m_acc[i] > 127) || (m_acc[i] < -128);
      end
    end
  endtask

  // Holds the result for `hold` cycles with a pending tile offered, then accepts it.
  task automatic drain(input int hold);
    for (int k = 0; k < hold; k++) begin
      garbage();
      in_valid  = 1'b1;
      out_ready = 1'b0;
      step();
    end
    garbage();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    exp_valid    = 1'b0;
    exp_in_ready = 1'b1;
    model_clear();
  endtask

  task automatic check_row0(input string nm, input int v, input bit s);
    chk({nm, "_model"}, exp_vout[0], v);
    chk({nm, "_val"}, int'($signed(value_out[0])), v);
    chk({nm, "_sat"}, int'(sat_flag[0]), int'(s));
  endtask

  task automatic scenario1(input string nm);
    bit fin;
    send_tile(mk_v(1, 2, 3, 4), mk_w(4'b1111, 4'b0000, 4'b0101, 4'b1010), 1'b1, fin);
    chk({nm, "_fin"}, int'(fin), 1);
    chk({nm, "_v0"}, int'($signed(value_out[0])), 10);
    chk({nm, "_v1"}, int'($signed(value_out[1])), -10);
    chk({nm, "_v2"}, int'($signed(value_out[2])), -2);
    chk({nm, "_v3"}, int'($signed(value_out[3])), 2);
    chk({nm, "_sat"}, int'(sat_flag), 0);
  endtask

  initial begin
    bit fin;
    logic [TOUT-1:0][TIN-1:0] all1;
    all1 = mk_w(4'hf, 4'hf, 4'hf, 4'hf);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; last_tile = 1'b0;
    value_in = '0; weight = '0;
    model_clear();
    exp_in_ready = 1'b0; exp_valid = 1'b0;
    for (int i = 0; i < TOUT; i++) begin exp_vout[i] = 0; exp_sat[i] = 1'b0; end
    step(); step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    exp_in_ready = 1'b1;
    step();

    scenario1("s1");
    drain(2);

    send_tile(mk_v(127, 127, 127, 127), all1, 1'b1, fin);
    check_row0("s2a", 127, 1'b1);
    drain(1);
    send_tile(mk_v(-128, -128, -128, -128), all1, 1'b1, fin);
    check_row0("s2b", -128, 1'b1);
    drain(0);
    send_tile(mk_v(-128, -128, -128, -128), '0, 1'b1, fin);
    check_row0("s2c", 127, 1'b1);
    drain(1);
    send_tile(mk_v(127, -128, 0, 0), mk_w(4'b0011, 4'b0011, 4'b0011, 4'b0011), 1'b1, fin);
    check_row0("s2d", -1, 1'b0);
    drain(1);

    for (int t = 1; t <= 3; t++) send_tile(mk_v(10, 10, 10, 10), all1, t == 3, fin);
    check_row0("s3a", 120, 1'b0);
    drain(1);
    for (int t = 1; t <= 4; t++) send_tile(mk_v(10, 10, 10, 10), all1, t == 4, fin);
    check_row0("s3b", 127, 1'b1);
    drain(1);

    for (int t = 1; t <= 4; t++) send_tile(mk_v(10, 10, -10, 10), all1, 1'b0, fin);
    chk("s4_forced", int'(fin), 1);
    check_row0("s4", 80, 1'b0);
    drain(3);

    scenario1("s5a");
    drain(5);
    send_tile(mk_v(1, 1, 1, 1), all1, 1'b1, fin);
    check_row0("s5b", 4, 1'b0);
    drain(0);

    send_tile(mk_v(50, 50, 50, 50), all1, 1'b0, fin);
    value_in = mk_v(60, 60, 60, 60); weight = all1; last_tile = 1'b1; in_valid = 1'b1;
    step();
    exp_in_ready = 1'b0;
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    model_clear();
    for (int i = 0; i < TOUT; i++) begin exp_vout[i] = 0; exp_sat[i] = 1'b0; end
    exp_valid = 1'b0;
    reset = 1'b0;
    exp_in_ready = 1'b1;
    step();
    scenario1("s6");
    drain(1);

    for (int n = 0; n < 25; n++) begin
      int lastpos;
      lastpos = $urandom_range(1, 5);
      for (int t = 1; t <= 4; t++) begin
        logic [TOUT-1:0][TIN-1:0] w;
        logic [31:0] r;
        r = $urandom;
        w = r[15:0];
        send_tile({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, w, t == lastpos, fin);
        if (fin) break;
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          garbage();
          in_valid = 1'b0;
          step();
        end
      end
      drain($urandom_range(0, 3));
    end

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
